decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked RV32I/M decode pipeline stage. Sits between fetch and execute.
- Generalises the combinational decoder with:
  - full RV32 immediate formation (I/S/B/U/J, sign-extended);
  - JAL/JALR/AUIPC support;
  - illegal-instruction detection;
  - optional M extension;
  - valid/ready flow control with optional skid buffering and flush.

Parameters:
- PC_W, 32, width of the pass-through program counter.
- ENABLE_M, 1, decode MUL/DIV group (funct7=0000001). When 0, these decode as illegal.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts when in_valid & in_ready at posedge
- in_instr  in  32  raw instruction
- in_pc  in  PC_W  instruction address
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes when out_valid & out_ready at posedge
- out_pc  out  PC_W  registered in_pc
- out_kind  out  4  KIND_* enum from package
- out_alu_op  out  4  ALU_* enum (ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 1000, SLT 1001, SLTU 1011, MUL 1100, DIV 1101)
- out_br_op  out  3  funct3 of branch, else 0
- out_imm  out  32  formed immediate
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_rs1_used, out_rs2_used  out  1 each  operand actually read
- out_reg_write  out  1  writes rd
- out_mem_read, out_mem_write  out  1 each  load / store
- out_mem_width  out  2  00 byte, 01 half, 10 word
- out_mem_unsigned  out  1  LBU/LHU
- out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, immediate): out_valid=0, skid empty, all out_* = 0. in_ready=1 from the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N.
- Output ordering: out_* stay stable while out_valid & ~out_ready. Order is strictly FIFO, with no loss or duplication.
- SKID=1 flow control:
  - Entries are the output register plus one skid register.
  - in_ready = ~skid_full, and is registered.
  - If the output is stalled and an accept occurs, the new entry goes to skid.
  - On consume, skid moves to the output register in the same edge.
  - Simultaneous consume and accept with skid occupied: skid moves to output, the new entry goes to skid.
- SKID=0 flow control: in_ready is combinational. Accept and consume may occur in the same edge; the new entry replaces the output.
- Flush:
  - At the edge with flush=1: out_valid=0 and skid emptied.
  - Any accept in that cycle is discarded.
  - flush dominates all other events. in_ready=1 next cycle.
- Immediates:
  - I: sext(instr[31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],0})
  - U: {[31:12],12'b0}
  - J: sext({[31],[19:12],[20],[30:21],0})
  - R-type: 0
- Shift-immediates: imm = zero-extended shamt. SRAI when instr[30]=1.
- Register usage:
  - rs1_used: R, I, LOAD, STORE, BRANCH, JALR.
  - rs2_used: R, STORE, BRANCH.
- reg_write:
  - 1 for R, I, LOAD, JAL, JALR, LUI, AUIPC.
  - Forced 0 when rd=0 or when illegal.
- Illegal conditions:
  - instr[1:0]≠11, or unknown opcode;
  - R funct7 not in {0000000, 0100000 (ADD/SUB, SRL/SRA only), 0000001 with ENABLE_M};
  - M funct3 other than 000/100;
  - load funct3 011/110/111;
  - store funct3 >010;
  - branch funct3 010/011;
  - JALR funct3≠000;
  - shift-imm with a bad upper field.
- Illegal handling: out_illegal=1, reg_write=mem_read=mem_write=0, kind=KIND_ILLEGAL. The bundle is still passed downstream with out_valid=1.
- Decode must be pure: no latches and no X propagation. Every combinational output is defaulted.

Decomposition:
- Package rv_decode_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), ALU_* and KIND_* enums, width codes, and a packed decoded-bundle struct.
- Sub-module decode_core: combinational instr→bundle decode.
- decode_stage wraps decode_core with the pipeline/skid registers.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, KIND_ALU_I, ADD, imm=0xFFFFFFFF, rd=1, reg_write=1, rs2_used=0.
- beq x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, br_op=000, rs1_used=rs2_used=1, reg_write=0.
- SKID=1, three back-to-back instrs, out_ready=0 → exactly 2 accepted, in_ready=0. Raise out_ready → drained in order, third accepted, no duplicates.
- Skid full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed and offered entries never appear.
- ENABLE_M=0: mul x3,x1,x2 (0x022081B3) → illegal=1, reg_write=0. 0x00000000 → illegal=1. ENABLE_M=1: same mul → ALU MUL, rd=3, reg_write=1.
- addi x0,x0,0 (0x00000013) → reg_write=0, not illegal. rst asserted mid-stall → out_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I/M decode types: opcodes, ALU and kind encodings, memory width
// codes and the packed bundle handed from decode to execute.
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1011,
    ALU_MUL  = 4'b1100,
    ALU_DIV  = 4'b1101
  } alu_op_e;

  // KIND_NONE is the all-zero reset value of an empty bundle.
  typedef enum logic [3:0] {
    KIND_NONE    = 4'd0,
    KIND_ALU_R   = 4'd1,
    KIND_ALU_I   = 4'd2,
    KIND_LOAD    = 4'd3,
    KIND_STORE   = 4'd4,
    KIND_BRANCH  = 4'd5,
    KIND_JAL     = 4'd6,
    KIND_JALR    = 4'd7,
    KIND_LUI     = 4'd8,
    KIND_AUIPC   = 4'd9,
    KIND_ILLEGAL = 4'd15
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    alu_op_e     alu_op;
    logic [2:0]  br_op;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
    logic        illegal;
  } dec_bundle_t;

  // funct3[1:0] of a load/store to the access width code.
  function automatic logic [1:0] width_code(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the stage itself, master = the surrounding pipeline.
interface decode_stage_if #(parameter int PC_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_kind;
  logic [3:0]      out_alu_op;
  logic [2:0]      out_br_op;
  logic [31:0]     out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [1:0]      out_mem_width;
  logic            out_mem_unsigned;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_kind, out_alu_op, out_br_op,
           out_imm, out_rs1, out_rs2, out_rd, out_rs1_used, out_rs2_used,
           out_reg_write, out_mem_read, out_mem_write, out_mem_width,
           out_mem_unsigned, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_kind, out_alu_op, out_br_op,
           out_imm, out_rs1, out_rs2, out_rd, out_rs1_used, out_rs2_used,
           out_reg_write, out_mem_read, out_mem_write, out_mem_width,
           out_mem_unsigned, out_illegal
  );
endinterface

// File: rtl/decode_core.sv
// Purely combinational RV32I(+M) instruction -> decoded bundle.
module decode_core
  import rv_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] i_instr,
  output dec_bundle_t o_dec
);

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  logic        w_ill;
  dec_bundle_t w_dec;

  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_instr[24:20]};

  // Field decode; everything defaults to zero so no path leaves X or a latch.
  always_comb begin
    w_dec     = '0;
    w_dec.rs1 = i_instr[19:15];
    w_dec.rs2 = i_instr[24:20];
    w_dec.rd  = i_instr[11:7];
    w_ill     = (i_instr[1:0] != 2'b11);
    case (w_opc)
      OPC_OP: begin
        w_dec.kind      = KIND_ALU_R;
        w_dec.rs1_used  = 1'b1;
        w_dec.rs2_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b001:  w_dec.alu_op = ALU_SLL;
            3'b010:  w_dec.alu_op = ALU_SLT;
            3'b011:  w_dec.alu_op = ALU_SLTU;
            3'b100:  w_dec.alu_op = ALU_XOR;
            3'b101:  w_dec.alu_op = ALU_SRL;
            3'b110:  w_dec.alu_op = ALU_OR;
            3'b111:  w_dec.alu_op = ALU_AND;
            default: w_dec.alu_op = ALU_ADD;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      w_dec.alu_op = ALU_SUB;
          else if (w_f3 == 3'b101) w_dec.alu_op = ALU_SRA;
          else                     w_ill = 1'b1;
        end else if (ENABLE_M && w_f7 == F7_MULD) begin
          if (w_f3 == 3'b000)      w_dec.alu_op = ALU_MUL;
          else if (w_f3 == 3'b100) w_dec.alu_op = ALU_DIV;
          else                     w_ill = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_dec.kind      = KIND_ALU_I;
        w_dec.rs1_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = w_imm_i;
        case (w_f3)
          3'b001: begin
            w_dec.alu_op = ALU_SLL;
            w_dec.imm    = w_imm_sh;
            if (w_f7 != F7_BASE) w_ill = 1'b1;
          end
          3'b101: begin
            w_dec.imm = w_imm_sh;
            if (w_f7 == F7_BASE)     w_dec.alu_op = ALU_SRL;
            else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SRA;
            else                     w_ill = 1'b1;
          end
          3'b010:  w_dec.alu_op = ALU_SLT;
          3'b011:  w_dec.alu_op = ALU_SLTU;
          3'b100:  w_dec.alu_op = ALU_XOR;
          3'b110:  w_dec.alu_op = ALU_OR;
          3'b111:  w_dec.alu_op = ALU_AND;
          default: w_dec.alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        w_dec.kind         = KIND_LOAD;
        w_dec.rs1_used     = 1'b1;
        w_dec.reg_write    = 1'b1;
        w_dec.mem_read     = 1'b1;
        w_dec.imm          = w_imm_i;
        w_dec.mem_width    = width_code(w_f3);
        w_dec.mem_unsigned = w_f3[2];
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
      end
      OPC_STORE: begin
        w_dec.kind      = KIND_STORE;
        w_dec.rs1_used  = 1'b1;
        w_dec.rs2_used  = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.mem_width = width_code(w_f3);
        if (w_f3 > 3'b010) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.kind     = KIND_BRANCH;
        w_dec.rs1_used = 1'b1;
        w_dec.rs2_used = 1'b1;
        w_dec.br_op    = w_f3;
        w_dec.imm      = w_imm_b;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
      end
      OPC_JAL: begin
        w_dec.kind      = KIND_JAL;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = w_imm_j;
      end
      OPC_JALR: begin
        w_dec.kind      = KIND_JALR;
        w_dec.rs1_used  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = w_imm_i;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      OPC_LUI: begin
        w_dec.kind      = KIND_LUI;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = w_imm_u;
      end
      OPC_AUIPC: begin
        w_dec.kind      = KIND_AUIPC;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal bundles still flow downstream, but must not touch state.
    if (w_ill) begin
      w_dec.kind         = KIND_ILLEGAL;
      w_dec.reg_write    = 1'b0;
      w_dec.mem_read     = 1'b0;
      w_dec.mem_write    = 1'b0;
      w_dec.br_op        = 3'b000;
      w_dec.mem_width    = 2'b00;
      w_dec.mem_unsigned = 1'b0;
    end
    w_dec.illegal = w_ill;
    if (w_dec.rd == 5'd0) w_dec.reg_write = 1'b0;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// Registered valid/ready decode stage between fetch and execute.
// SKID=1: output register + one skid entry, registered in_ready.
// SKID=0: single output register, combinational in_ready.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter bit SKID     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    dec_bundle_t     dec;
  } entry_t;

  dec_bundle_t w_dec;
  entry_t      w_new, w_out;
  logic        w_out_vld, w_in_ready, w_accept, w_consume;

  decode_core #(.ENABLE_M(ENABLE_M)) u_core (
    .i_instr (bus.in_instr),
    .o_dec   (w_dec)
  );

  assign w_new     = '{pc: bus.in_pc, dec: w_dec};
  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_consume = w_out_vld & bus.out_ready;

  if (SKID) begin : g_skid
    entry_t r_out, r_skid;
    logic   r_out_vld, r_skid_vld, r_in_ready;

    // Two-entry FIFO: skid only fills while the output is stalled, and
    // in_ready tracks the next skid occupancy so it is a clean flop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out      <= '0;
        r_skid     <= '0;
        r_out_vld  <= 1'b0;
        r_skid_vld <= 1'b0;
        r_in_ready <= 1'b1;
      end else if (bus.flush) begin
        r_out_vld  <= 1'b0;
        r_skid_vld <= 1'b0;
        r_in_ready <= 1'b1;
      end else if (!r_out_vld) begin
        if (w_accept) begin
          r_out     <= w_new;
          r_out_vld <= 1'b1;
        end
      end else if (w_consume) begin
        if (r_skid_vld) begin
          r_out <= r_skid;
          if (w_accept) begin
            r_skid <= w_new;
          end else begin
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end else if (w_accept) begin
          r_out <= w_new;
        end else begin
          r_out_vld <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid     <= w_new;
        r_skid_vld <= 1'b1;
        r_in_ready <= 1'b0;
      end
    end

    assign w_out      = r_out;
    assign w_out_vld  = r_out_vld;
    assign w_in_ready = r_in_ready;
  end else begin : g_noskid
    entry_t r_out;
    logic   r_out_vld;

    // Single register: a new accept overwrites the entry being consumed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out     <= '0;
        r_out_vld <= 1'b0;
      end else if (bus.flush) begin
        r_out_vld <= 1'b0;
      end else if (w_accept) begin
        r_out     <= w_new;
        r_out_vld <= 1'b1;
      end else if (w_consume) begin
        r_out_vld <= 1'b0;
      end
    end

    assign w_out      = r_out;
    assign w_out_vld  = r_out_vld;
    assign w_in_ready = bus.out_ready | ~r_out_vld;
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.out_valid        = w_out_vld;
  assign bus.out_pc           = w_out.pc;
  assign bus.out_kind         = w_out.dec.kind;
  assign bus.out_alu_op       = w_out.dec.alu_op;
  assign bus.out_br_op        = w_out.dec.br_op;
  assign bus.out_imm          = w_out.dec.imm;
  assign bus.out_rs1          = w_out.dec.rs1;
  assign bus.out_rs2          = w_out.dec.rs2;
  assign bus.out_rd           = w_out.dec.rd;
  assign bus.out_rs1_used     = w_out.dec.rs1_used;
  assign bus.out_rs2_used     = w_out.dec.rs2_used;
  assign bus.out_reg_write    = w_out.dec.reg_write;
  assign bus.out_mem_read     = w_out.dec.mem_read;
  assign bus.out_mem_write    = w_out.dec.mem_write;
  assign bus.out_mem_width    = w_out.dec.mem_width;
  assign bus.out_mem_unsigned = w_out.dec.mem_unsigned;
  assign bus.out_illegal      = w_out.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: u_dut is SKID=1/ENABLE_M=1, u_alt is SKID=0/ENABLE_M=0.
module tb_decode_stage;
  import rv_decode_pkg::*;

  logic clk, rst;
  int   checks, errors;

  decode_stage_if #(.PC_W(32)) m_if ();
  decode_stage_if #(.PC_W(32)) a_if ();

  decode_stage #(.PC_W(32), .ENABLE_M(1'b1), .SKID(1'b1)) u_dut (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  decode_stage #(.PC_W(32), .ENABLE_M(1'b0), .SKID(1'b0)) u_alt (
    .clk (clk), .rst (rst), .bus (a_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    m_if.in_valid = v;
    m_if.in_instr = instr;
    m_if.in_pc    = pc;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    a_if.in_valid = v;
    a_if.in_instr = instr;
    a_if.in_pc    = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    m_drive(1'b0, 32'h0, 32'h0);
    a_drive(1'b0, 32'h0, 32'h0);
    m_if.flush = 1'b0; m_if.out_ready = 1'b0;
    a_if.flush = 1'b0; a_if.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    chk("rst_out_kind",  32'(m_if.out_kind),  32'd0);
    chk("rst_out_imm",   m_if.out_imm,        32'd0);
    chk("rst_alt_valid", 32'(a_if.out_valid), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", 32'(m_if.in_ready), 32'd1);
    chk("alt_in_ready_after_rst", 32'(a_if.in_ready), 32'd1);

    // addi x1,x0,-1
    m_if.out_ready = 1'b1;
    m_drive(1'b1, 32'hFFF00093, 32'h100);
    step();
    m_drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid",  32'(m_if.out_valid),     32'd1);
    chk("addi_kind",   32'(m_if.out_kind),      32'(KIND_ALU_I));
    chk("addi_alu",    32'(m_if.out_alu_op),    32'(ALU_ADD));
    chk("addi_imm",    m_if.out_imm,            32'hFFFFFFFF);
    chk("addi_rd",     32'(m_if.out_rd),        32'd1);
    chk("addi_rw",     32'(m_if.out_reg_write), 32'd1);
    chk("addi_rs2u",   32'(m_if.out_rs2_used),  32'd0);
    chk("addi_pc",     m_if.out_pc,             32'h100);

    // beq x0,x0,-4
    m_drive(1'b1, 32'hFE000EE3, 32'h104);
    step();
    m_drive(1'b0, 32'h0, 32'h0);
    chk("beq_kind", 32'(m_if.out_kind),      32'(KIND_BRANCH));
    chk("beq_imm",  m_if.out_imm,            32'hFFFFFFFC);
    chk("beq_brop", 32'(m_if.out_br_op),     32'd0);
    chk("beq_rs1u", 32'(m_if.out_rs1_used),  32'd1);
    chk("beq_rs2u", 32'(m_if.out_rs2_used),  32'd1);
    chk("beq_rw",   32'(m_if.out_reg_write), 32'd0);
    chk("beq_pc",   m_if.out_pc,             32'h104);
    step();
    chk("drain_empty", 32'(m_if.out_valid), 32'd0);

    // Back-to-back decode with continuous consume.
    m_drive(1'b1, 32'h00812283, 32'h110);          // lw x5,8(x2)
    step();
    chk("lw_kind",  32'(m_if.out_kind),      32'(KIND_LOAD));
    chk("lw_imm",   m_if.out_imm,            32'd8);
    chk("lw_rs1",   32'(m_if.out_rs1),       32'd2);
    chk("lw_mr",    32'(m_if.out_mem_read),  32'd1);
    chk("lw_width", 32'(m_if.out_mem_width), 32'(MEM_W));
    m_drive(1'b1, 32'h00014283, 32'h114);          // lbu x5,0(x2)
    step();
    chk("lbu_uns",   32'(m_if.out_mem_unsigned), 32'd1);
    chk("lbu_width", 32'(m_if.out_mem_width),    32'(MEM_B));
    m_drive(1'b1, 32'hFE512E23, 32'h118);          // sw x5,-4(x2)
    step();
    chk("sw_imm", m_if.out_imm,            32'hFFFFFFFC);
    chk("sw_mw",  32'(m_if.out_mem_write), 32'd1);
    chk("sw_rw",  32'(m_if.out_reg_write), 32'd0);
    chk("sw_rs2", 32'(m_if.out_rs2),       32'd5);
    m_drive(1'b1, 32'h123453B7, 32'h11C);          // lui x7,0x12345
    step();
    chk("lui_imm", m_if.out_imm,      32'h12345000);
    chk("lui_rd",  32'(m_if.out_rd),  32'd7);
    m_drive(1'b1, 32'h008000EF, 32'h120);          // jal x1,+8
    step();
    chk("jal_kind", 32'(m_if.out_kind), 32'(KIND_JAL));
    chk("jal_imm",  m_if.out_imm,       32'd8);
    chk("jal_rw",   32'(m_if.out_reg_write), 32'd1);
    m_drive(1'b1, 32'h4030D093, 32'h124);          // srai x1,x1,3
    step();
    chk("srai_alu", 32'(m_if.out_alu_op), 32'(ALU_SRA));
    chk("srai_imm", m_if.out_imm,         32'd3);
    m_drive(1'b1, 32'h2030D093, 32'h128);          // shift-imm, bad upper field
    step();
    chk("badsh_ill",  32'(m_if.out_illegal),   32'd1);
    chk("badsh_kind", 32'(m_if.out_kind),      32'(KIND_ILLEGAL));
    chk("badsh_rw",   32'(m_if.out_reg_write), 32'd0);
    m_drive(1'b1, 32'h00000013, 32'h12C);          // addi x0,x0,0
    step();
    chk("nop_rw",  32'(m_if.out_reg_write), 32'd0);
    chk("nop_ill", 32'(m_if.out_illegal),   32'd0);

    // mul x3,x1,x2 on both configurations.
    m_drive(1'b1, 32'h022081B3, 32'h130);
    a_if.out_ready = 1'b1;
    a_drive(1'b1, 32'h022081B3, 32'h130);
    step();
    m_drive(1'b0, 32'h0, 32'h0);
    chk("mul_m_alu",  32'(m_if.out_alu_op),    32'(ALU_MUL));
    chk("mul_m_rd",   32'(m_if.out_rd),        32'd3);
    chk("mul_m_rw",   32'(m_if.out_reg_write), 32'd1);
    chk("mul_m_kind", 32'(m_if.out_kind),      32'(KIND_ALU_R));
    chk("mul_nom_ill",   32'(a_if.out_illegal),   32'd1);
    chk("mul_nom_rw",    32'(a_if.out_reg_write), 32'd0);
    chk("mul_nom_valid", 32'(a_if.out_valid),     32'd1);
    a_drive(1'b1, 32'h00000000, 32'h134);
    step();
    chk("zero_ill",  32'(a_if.out_illegal), 32'd1);
    chk("zero_kind", 32'(a_if.out_kind),    32'(KIND_ILLEGAL));

    // SKID=0: stall, replace on simultaneous consume, flush discards accept.
    a_if.out_ready = 1'b0;
    a_drive(1'b1, 32'h00100093, 32'h500);
    #1;
    chk("s0_stall_ready", 32'(a_if.in_ready), 32'd0);
    a_if.out_ready = 1'b1;
    #1;
    chk("s0_comb_ready", 32'(a_if.in_ready), 32'd1);
    step();
    chk("s0_replace_pc",   a_if.out_pc,         32'h500);
    chk("s0_replace_kind", 32'(a_if.out_kind),  32'(KIND_ALU_I));
    a_drive(1'b1, 32'h00200113, 32'h504);
    a_if.flush = 1'b1;
    step();
    a_if.flush = 1'b0;
    a_drive(1'b0, 32'h0, 32'h0);
    chk("s0_flush_valid", 32'(a_if.out_valid), 32'd0);
    chk("s0_flush_ready", 32'(a_if.in_ready),  32'd1);
    step();
    chk("s0_flush_nothing", 32'(a_if.out_valid), 32'd0);

    // SKID=1: three offers against a stalled output.
    step();
    chk("skid_pre_empty", 32'(m_if.out_valid), 32'd0);
    m_if.out_ready = 1'b0;
    m_drive(1'b1, 32'h00100093, 32'h200);
    step();
    chk("skid_a_ready", 32'(m_if.in_ready), 32'd1);
    chk("skid_a_pc",    m_if.out_pc,        32'h200);
    m_drive(1'b1, 32'h00200113, 32'h204);
    step();
    chk("skid_full_ready", 32'(m_if.in_ready), 32'd0);
    chk("skid_hold_pc",    m_if.out_pc,        32'h200);
    m_drive(1'b1, 32'h00300193, 32'h208);
    step();
    chk("skid_c_refused", 32'(m_if.in_ready), 32'd0);
    chk("skid_hold_pc2",  m_if.out_pc,        32'h200);
    m_if.out_ready = 1'b1;
    step();
    chk("drain_b_pc",    m_if.out_pc,        32'h204);
    chk("drain_b_ready", 32'(m_if.in_ready), 32'd1);
    step();
    m_drive(1'b0, 32'h0, 32'h0);
    chk("drain_c_pc", m_if.out_pc,       32'h208);
    chk("drain_c_rd", 32'(m_if.out_rd),  32'd3);
    step();
    chk("drain_done", 32'(m_if.out_valid), 32'd0);

    // SKID=1: flush with skid full and a new offer.
    m_if.out_ready = 1'b0;
    m_drive(1'b1, 32'h00100093, 32'h300);
    step();
    m_drive(1'b1, 32'h00200113, 32'h304);
    step();
    chk("fl_full_ready", 32'(m_if.in_ready), 32'd0);
    m_drive(1'b1, 32'h00300193, 32'h308);
    m_if.flush = 1'b1;
    step();
    m_if.flush = 1'b0;
    m_drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 32'(m_if.out_valid), 32'd0);
    chk("fl_ready", 32'(m_if.in_ready),  32'd1);
    m_if.out_ready = 1'b1;
    step();
    chk("fl_no_resurface", 32'(m_if.out_valid), 32'd0);
    step();
    chk("fl_no_resurface2", 32'(m_if.out_valid), 32'd0);

    // Reset while stalled.
    m_if.out_ready = 1'b0;
    m_drive(1'b1, 32'h00100093, 32'h600);
    step();
    m_drive(1'b0, 32'h0, 32'h0);
    chk("rs_stall_valid", 32'(m_if.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 32'(m_if.out_valid), 32'd0);
    chk("rs_async_pc",    m_if.out_pc,         32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rs_ready_after", 32'(m_if.in_ready),  32'd1);
    chk("rs_valid_after", 32'(m_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
